// File: rtl/game_state_fsm.sv
// Game-flow controller: sequences IDLE/PLAY/PAUSE/WIN/LOSE from buttons, HP levels and an
// optional round timer; latches the outcome and counts wins.
module game_state_fsm #(
  parameter int unsigned BOSS_HP_W   = 10,
  parameter int unsigned PLAYER_HP_W = 2,
  parameter int unsigned NUM_PLAYERS = 1,
  parameter int unsigned TIME_LIMIT  = 0,
  parameter int unsigned TIME_W      = 8,
  parameter int unsigned WIN_CNT_W   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_btn,
  input  logic                               pause_btn,
  input  logic                               sec_tick,
  input  logic [BOSS_HP_W-1:0]               boss_hp,
  input  logic [NUM_PLAYERS*PLAYER_HP_W-1:0] player_hp,
  output logic [2:0]                         game_state,
  output logic [NUM_PLAYERS-1:0]             players_alive,
  output logic [TIME_W-1:0]                  time_left,
  output logic                               state_changed,
  output logic [WIN_CNT_W-1:0]               win_count
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPlay  = 3'd1,
    StPause = 3'd2,
    StWin   = 3'd3,
    StLose  = 3'd4
  } state_e;

  localparam logic [TIME_W-1:0]    TimeInit = TIME_W'(TIME_LIMIT);
  localparam bit                   TimerEn  = (TIME_LIMIT != 0);
  localparam logic [WIN_CNT_W-1:0] WinMax   = '1;

  state_e                 r_state, w_state_next;
  logic [NUM_PLAYERS-1:0] r_alive, w_alive;
  logic [TIME_W-1:0]      r_time_left, w_time_next;
  logic                   r_state_changed;
  logic [WIN_CNT_W-1:0]   r_win_count, w_win_next;
  logic                   w_boss_dead;
  logic                   w_party_dead;
  logic                   w_timeout;

  // Per-player liveness straight from the live HP bus, so a death is judged this cycle.
  always_comb begin
    w_alive = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_alive[i] = |player_hp[i*PLAYER_HP_W +: PLAYER_HP_W];
    end
  end

  assign w_boss_dead  = (boss_hp == '0);
  assign w_party_dead = (w_alive == '0);
  assign w_timeout    = TimerEn && (r_time_left == '0);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start_btn) w_state_next = StPlay;
      end
      StPlay: begin
        if (w_boss_dead)       w_state_next = StWin;
        else if (w_party_dead) w_state_next = StLose;
        else if (w_timeout)    w_state_next = StLose;
        else if (pause_btn)    w_state_next = StPause;
      end
      StPause: begin
        if (pause_btn) w_state_next = StPlay;
      end
      StWin, StLose: begin
        if (start_btn) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_time_next = r_time_left;
    if (r_state == StIdle && start_btn) begin
      w_time_next = TimeInit;
    end else if (r_state == StPlay && TimerEn && sec_tick && r_time_left != '0) begin
      w_time_next = r_time_left - 1'b1;
    end
  end

  always_comb begin
    w_win_next = r_win_count;
    if (w_state_next == StWin && r_state != StWin && r_win_count != WinMax) begin
      w_win_next = r_win_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= StIdle;
      r_alive         <= '0;
      r_time_left     <= TimeInit;
      r_state_changed <= 1'b0;
      r_win_count     <= '0;
    end else begin
      r_state         <= w_state_next;
      r_alive         <= w_alive;
      r_time_left     <= w_time_next;
      r_state_changed <= (w_state_next != r_state);
      r_win_count     <= w_win_next;
    end
  end

  assign game_state    = r_state;
  assign players_alive = r_alive;
  assign time_left     = r_time_left;
  assign state_changed = r_state_changed;
  assign win_count     = r_win_count;

endmodule
